// File: rtl/asynch_fifo_pkg.sv
// Shared types and default widths for the async FIFO and its read-side stages.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package asynch_fifo_pkg;

  // Default word width and address width, shared by the FIFO top and its read-side stages.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Occupancy of the two-entry read-side prefetch buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rd_occ_e;

endpackage

// File: rtl/fifo_rd_stream_adapter.sv
// Pops the async FIFO read port into a registered valid/ready stream through a 2-entry prefetch buffer.
// Latency: 1 cycle from the pop (rinc) to m_valid/m_data; sustains 1 word/cycle.
// Backpressure: m_ready=0 fills head+skid, then rinc drops until a dequeue frees a slot.
module fifo_rd_stream_adapter
  import asynch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rempty,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  pop_cnt
);

  rd_occ_e               state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  m_valid_q;
  logic [CNT_WIDTH-1:0]  pop_cnt_q;
  logic                  deq;

  // A pop is allowed whenever a buffer slot is free now or is being freed by this cycle's dequeue.
  assign deq     = m_valid_q & m_ready;
  assign rinc    = rrst_n & ~flush & ~rempty & ((state_q != TWO) | deq);
  assign m_data  = head_q;
  assign m_valid = m_valid_q;
  assign pop_cnt = pop_cnt_q;

  // Next occupancy and buffer contents; flush discards everything and wins over enq/deq.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (rinc) begin
            state_d = ONE;
            head_d  = rdata;
          end
        end
        ONE: begin
          if (rinc && !deq) begin
            state_d = TWO;
            skid_d  = rdata;
          end else if (rinc && deq) begin
            head_d = rdata;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (deq) begin
            head_d = skid_q;
            if (rinc) begin
              skid_d = rdata;
            end else begin
              state_d = ONE;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, output registers and the saturating pop counter (flush leaves the counter alone).
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      m_valid_q <= 1'b0;
      pop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      m_valid_q <= (state_d != EMPTY);
      if (rinc && (pop_cnt_q != {CNT_WIDTH{1'b1}})) begin
        pop_cnt_q <= pop_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for the FIFO read-side stream adapter: directed scenarios plus a randomized run against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_rd_stream_adapter;

  logic       rclk;
  logic       rrst_n;
  logic [7:0] rdata;
  logic       rempty;
  logic       m_ready;
  logic       flush;

  logic       rinc, rinc_s;
  logic [7:0] m_data, m_data_s;
  logic       m_valid, m_valid_s;
  logic [15:0] pop_cnt;
  logic [3:0]  pop_cnt_s;

  int checks;
  int failures;

  // Reference: buffered words in order, plus an unbounded count of pops.
  logic [7:0] q[$];
  int         cnt;

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .flush(flush), .pop_cnt(pop_cnt)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc_s),
    .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready), .flush(flush), .pop_cnt(pop_cnt_s)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A word is taken when the buffer has room now or gets room from this cycle's handshake.
  function automatic bit exp_rinc();
    return rrst_n && !flush && !rempty && (q.size() < 2 || (q.size() > 0 && m_ready));
  endfunction

  // Model update on every clock edge.
  always @(posedge rclk) begin
    bit take;
    take = exp_rinc();
    if (!rrst_n) begin
      q.delete();
      cnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (m_ready && q.size() > 0) void'(q.pop_front());
      if (take) begin
        q.push_back(rdata);
        cnt++;
      end
    end
  end

  // Compare process: mid-cycle, outputs and inputs are stable.
  always @(negedge rclk) begin
    chk("rinc", {31'd0, rinc}, {31'd0, exp_rinc()});
    chk("rinc_sat", {31'd0, rinc_s}, {31'd0, exp_rinc()});
    chk("m_valid", {31'd0, m_valid}, {31'd0, q.size() > 0});
    chk("m_valid_sat", {31'd0, m_valid_s}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("m_data", {24'd0, m_data}, {24'd0, q[0]});
      chk("m_data_sat", {24'd0, m_data_s}, {24'd0, q[0]});
    end
    chk("pop_cnt", {16'd0, pop_cnt}, (cnt > 65535) ? 32'd65535 : cnt);
    chk("pop_cnt_sat", {28'd0, pop_cnt_s}, (cnt > 15) ? 32'd15 : cnt);
  end

  // Advance past the next rising edge, apply inputs, then wait to mid-cycle.
  task automatic step(input logic rst_n_i, input logic empty_i, input logic [7:0] d_i,
                      input logic rdy_i, input logic flush_i);
    @(posedge rclk);
    #2;
    rrst_n  = rst_n_i;
    rempty  = empty_i;
    rdata   = d_i;
    m_ready = rdy_i;
    flush   = flush_i;
    @(negedge rclk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cnt      = 0;
    rrst_n   = 1'b0;
    rempty   = 1'b0;
    rdata    = 8'h5A;
    m_ready  = 1'b1;
    flush    = 1'b0;

    // Reset held for 3 cycles with a word available: no pops.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
      chk("rst_rinc", {31'd0, rinc}, 32'd0);
    end
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'h00);
    chk("rst_pop_cnt", {16'd0, pop_cnt}, 32'd0);

    // Single word.
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    chk("single_rinc", {31'd0, rinc}, 32'd1);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("single_valid", {31'd0, m_valid}, 32'd1);
    chk("single_data", {24'd0, m_data}, 32'hA5);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("single_valid_off", {31'd0, m_valid}, 32'd0);
    chk("single_cnt", {16'd0, pop_cnt}, 32'd1);

    // Streaming 16 words back to back.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
      chk("stream_rinc", {31'd0, rinc}, 32'd1);
      if (i > 0) chk("stream_data", {24'd0, m_data}, i - 1);
    end
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("stream_last", {24'd0, m_data}, 32'h0F);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("stream_drained", {31'd0, m_valid}, 32'd0);
    chk("stream_cnt", {16'd0, pop_cnt}, 32'd17);

    // Backpressure: two pops fill the buffer, then the pop strobe stays low.
    step(1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    chk("bp_pop0", {31'd0, rinc}, 32'd1);
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    chk("bp_pop1", {31'd0, rinc}, 32'd1);
    step(1'b1, 1'b0, 8'h12, 1'b0, 1'b0);
    chk("bp_full_rinc", {31'd0, rinc}, 32'd0);
    chk("bp_hold_data", {24'd0, m_data}, 32'h10);
    step(1'b1, 1'b0, 8'h12, 1'b0, 1'b0);
    chk("bp_hold_data2", {24'd0, m_data}, 32'h10);
    step(1'b1, 1'b0, 8'h12, 1'b1, 1'b0);
    chk("bp_pop_on_deq", {31'd0, rinc}, 32'd1);
    chk("bp_out0", {24'd0, m_data}, 32'h10);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("bp_out1", {24'd0, m_data}, 32'h11);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("bp_out2", {24'd0, m_data}, 32'h12);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("bp_drained", {31'd0, m_valid}, 32'd0);

    // Flush from a full buffer holding 0x20,0x21.
    step(1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h21, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
    chk("flush_rinc", {31'd0, rinc}, 32'd0);
    step(1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    chk("flush_valid_off", {31'd0, m_valid}, 32'd0);
    chk("flush_cnt", {16'd0, pop_cnt}, 32'd22);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("flush_next_valid", {31'd0, m_valid}, 32'd1);
    chk("flush_next_data", {24'd0, m_data}, 32'h22);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

    // Narrow counter is pinned at all-ones after more than 15 pops.
    chk("sat_cnt", {28'd0, pop_cnt_s}, 32'hF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("sat_no_wrap", {28'd0, pop_cnt_s}, 32'hF);
    chk("wide_cnt", {16'd0, pop_cnt}, 32'd26);

    // Randomized traffic, flushes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 4),
           8'($urandom),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
